// File: rtl/issue_group_buffer.sv
// Holds one fetched 4-slot group and presents it to the load/store checker until every valid slot issues.
// Optional `ISSUE_STATS_EN adds the replay counter and the sticky hang detector; without it both outputs read 0.
module issue_group_buffer #(
  parameter int INS_W      = 16,
  parameter int HANG_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             grp_valid,
  output logic             grp_ready,
  input  logic [3:0]       grp_vmask,
  input  logic [INS_W-1:0] grp_ins1,
  input  logic [INS_W-1:0] grp_ins2,
  input  logic [INS_W-1:0] grp_ins3,
  input  logic [INS_W-1:0] grp_ins4,
  output logic [3:0]       op1,
  output logic [3:0]       op2,
  output logic [3:0]       op3,
  output logic [3:0]       op4,
  output logic             ins1_history,
  output logic             ins2_history,
  output logic             ins3_history,
  output logic             ins4_history,
  input  logic             ins1_out,
  input  logic             ins2_out,
  input  logic             ins3_out,
  input  logic             ins4_out,
  input  logic             stall,
  output logic [3:0]       iss_mask,
  output logic [INS_W-1:0] iss_ins1,
  output logic [INS_W-1:0] iss_ins2,
  output logic [INS_W-1:0] iss_ins3,
  output logic [INS_W-1:0] iss_ins4,
  output logic             busy,
  output logic             hang,
  output logic [15:0]      replay_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [3:0][INS_W-1:0]   ins_q, ins_d;
  logic [3:0]              pending_q, pending_d;
  logic [3:0]              outs, grant, pend_next;
  logic                    accept;

  assign outs      = {ins4_out, ins3_out, ins2_out, ins1_out};
  assign grant     = pending_q & outs & {4{~stall}};
  assign pend_next = pending_q & ~grant;
  // A new group may land in the same cycle the last pending slot issues.
  assign grp_ready = (state_q == IDLE) | ((state_q == HOLD) & (pend_next == 4'b0000));
  assign accept    = grp_valid & grp_ready;

  assign iss_mask = grant;
  assign busy     = (state_q == HOLD);
  assign {ins4_history, ins3_history, ins2_history, ins1_history} = pending_q;
  assign op1 = ins_q[0][INS_W-1 -: 4];
  assign op2 = ins_q[1][INS_W-1 -: 4];
  assign op3 = ins_q[2][INS_W-1 -: 4];
  assign op4 = ins_q[3][INS_W-1 -: 4];
  assign iss_ins1 = ins_q[0];
  assign iss_ins2 = ins_q[1];
  assign iss_ins3 = ins_q[2];
  assign iss_ins4 = ins_q[3];

  always_comb begin
    state_d   = state_q;
    ins_d     = ins_q;
    pending_d = pending_q;
    if (accept) begin
      ins_d     = {grp_ins4, grp_ins3, grp_ins2, grp_ins1};
      pending_d = grp_vmask;
      // An all-invalid group is consumed and dropped.
      state_d   = (grp_vmask != 4'b0000) ? HOLD : IDLE;
    end else if (state_q == HOLD) begin
      pending_d = pend_next;
      if (pend_next == 4'b0000) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ins_q     <= '0;
      pending_q <= 4'b0000;
    end else begin
      state_q   <= state_d;
      ins_q     <= ins_d;
      pending_q <= pending_d;
    end
  end

`ifdef ISSUE_STATS_EN
  localparam int HC_W = $clog2(HANG_LIMIT + 1);

  logic            first_q, first_d;
  logic            drain;
  logic [HC_W-1:0] hang_cnt_q, hang_cnt_d;
  logic            hang_q, hang_d;
  logic [15:0]     replay_q, replay_d;

  assign drain = (state_q == HOLD) & (pend_next == 4'b0000);

  always_comb begin
    first_d    = first_q;
    replay_d   = replay_q;
    hang_cnt_d = '0;
    if (accept)                first_d = 1'b1;
    else if (grant != 4'b0000) first_d = 1'b0;
    // first_q==0 at drain means an earlier cycle already issued part of this group.
    if (drain && !first_q && (replay_q != 16'hFFFF)) replay_d = replay_q + 16'd1;
    if (state_q == HOLD) begin
      if (stall)
        hang_cnt_d = hang_cnt_q;
      else if (grant == 4'b0000)
        hang_cnt_d = (hang_cnt_q == HC_W'(HANG_LIMIT)) ? hang_cnt_q : hang_cnt_q + HC_W'(1);
    end
    hang_d = hang_q | (hang_cnt_d == HC_W'(HANG_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q    <= 1'b0;
      replay_q   <= 16'd0;
      hang_cnt_q <= '0;
      hang_q     <= 1'b0;
    end else begin
      first_q    <= first_d;
      replay_q   <= replay_d;
      hang_cnt_q <= hang_cnt_d;
      hang_q     <= hang_d;
    end
  end

  assign hang       = hang_q;
  assign replay_cnt = replay_q;
`else
  assign hang       = 1'b0;
  assign replay_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_issue_group_buffer.sv
// Directed bench for issue_group_buffer; expected values are hand-computed per step.
module tb_issue_group_buffer;

`ifdef ISSUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        grp_valid;
  logic        grp_ready;
  logic [3:0]  grp_vmask;
  logic [15:0] grp_ins1, grp_ins2, grp_ins3, grp_ins4;
  logic [3:0]  op1, op2, op3, op4;
  logic        ins1_history, ins2_history, ins3_history, ins4_history;
  logic [3:0]  outs;
  logic        stall;
  logic [3:0]  iss_mask;
  logic [15:0] iss_ins1, iss_ins2, iss_ins3, iss_ins4;
  logic        busy, hang;
  logic [15:0] replay_cnt;
  logic [3:0]  hist;

  int n_vec = 0;
  int n_err = 0;

  assign hist = {ins4_history, ins3_history, ins2_history, ins1_history};

  always #5 clk = ~clk;

  issue_group_buffer #(.INS_W(16), .HANG_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .grp_valid(grp_valid), .grp_ready(grp_ready), .grp_vmask(grp_vmask),
    .grp_ins1(grp_ins1), .grp_ins2(grp_ins2), .grp_ins3(grp_ins3), .grp_ins4(grp_ins4),
    .op1(op1), .op2(op2), .op3(op3), .op4(op4),
    .ins1_history(ins1_history), .ins2_history(ins2_history),
    .ins3_history(ins3_history), .ins4_history(ins4_history),
    .ins1_out(outs[0]), .ins2_out(outs[1]), .ins3_out(outs[2]), .ins4_out(outs[3]),
    .stall(stall), .iss_mask(iss_mask),
    .iss_ins1(iss_ins1), .iss_ins2(iss_ins2), .iss_ins3(iss_ins3), .iss_ins4(iss_ins4),
    .busy(busy), .hang(hang), .replay_cnt(replay_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] m, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    grp_valid = 1'b1;
    grp_vmask = m;
    grp_ins1 = a; grp_ins2 = b; grp_ins3 = c; grp_ins4 = d;
  endtask

  initial begin
    rst = 1'b1; grp_valid = 1'b0; grp_vmask = 4'b0000; outs = 4'b0000; stall = 1'b0;
    grp_ins1 = '0; grp_ins2 = '0; grp_ins3 = '0; grp_ins4 = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 'h0);
    check("rst_ready", 32'(grp_ready), 'h1);
    check("rst_hist", 32'(hist), 'h0);
    check("rst_op1", 32'(op1), 'h0);
    check("rst_iss", 32'(iss_mask), 'h0);
    check("rst_hang", 32'(hang), 'h0);
    check("rst_replay", 32'(replay_cnt), 'h0);

    // Full ALU group drained in one cycle
    offer(4'b1111, 16'h1001, 16'h1002, 16'h1003, 16'h1004);
    #1 check("a_ready", 32'(grp_ready), 'h1);
    tick();
    grp_valid = 1'b0;
    #1;
    check("a_hist", 32'(hist), 'hF);
    check("a_busy", 32'(busy), 'h1);
    check("a_op1", 32'(op1), 'h1);
    check("a_iss3", 32'(iss_ins3), 'h1003);
    outs = 4'b1111;
    #1;
    check("a_mask", 32'(iss_mask), 'hF);
    check("a_ready2", 32'(grp_ready), 'h1);
    tick();
    outs = 4'b0000;
    #1;
    check("a_idle", 32'(busy), 'h0);
    check("a_hist0", 32'(hist), 'h0);
    check("a_replay", 32'(replay_cnt), 'h0);

    // Loads in slots 1 and 3, issued over two cycles
    offer(4'b1111, 16'h2aaa, 16'h1bbb, 16'h2ccc, 16'h1ddd);
    tick();
    grp_valid = 1'b0;
    #1;
    check("b_op1", 32'(op1), 'h2);
    check("b_op2", 32'(op2), 'h1);
    check("b_op3", 32'(op3), 'h2);
    check("b_op4", 32'(op4), 'h1);
    outs = 4'b0011;
    #1;
    check("b_mask1", 32'(iss_mask), 'h3);
    check("b_ready1", 32'(grp_ready), 'h0);
    tick();
    check("b_hist1", 32'(hist), 'hC);
    outs = 4'b1100;
    #1;
    check("b_mask2", 32'(iss_mask), 'hC);
    check("b_ready2", 32'(grp_ready), 'h1);
    tick();
    outs = 4'b0000;
    #1;
    check("b_hist2", 32'(hist), 'h0);
    check("b_busy", 32'(busy), 'h0);
    check("b_replay", 32'(replay_cnt), STATS ? 'h1 : 'h0);

    // Stall holds everything for three cycles
    offer(4'b1111, 16'h3001, 16'h3002, 16'h3003, 16'h3004);
    tick();
    grp_valid = 1'b0;
    outs = 4'b1111; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("c_stall_mask", 32'(iss_mask), 'h0);
      check("c_stall_ready", 32'(grp_ready), 'h0);
      tick();
      check("c_stall_hist", 32'(hist), 'hF);
    end
    check("c_hang", 32'(hang), 'h0);
    stall = 1'b0;
    #1 check("c_mask", 32'(iss_mask), 'hF);
    tick();
    outs = 4'b0000;
    #1;
    check("c_hist", 32'(hist), 'h0);
    check("c_replay", 32'(replay_cnt), STATS ? 'h1 : 'h0);

    // Back-to-back: last grant of D with accept of E
    offer(4'b0101, 16'h4111, 16'h0000, 16'h4333, 16'h0000);
    tick();
    outs = 4'b0101;
    offer(4'b1010, 16'h0000, 16'h5222, 16'h0000, 16'h5444);
    #1;
    check("d_mask", 32'(iss_mask), 'h5);
    check("d_ready", 32'(grp_ready), 'h1);
    tick();
    grp_valid = 1'b0; outs = 4'b1111;
    #1;
    check("e_hist", 32'(hist), 'hA);
    check("e_busy", 32'(busy), 'h1);
    check("e_op2", 32'(op2), 'h5);
    check("e_iss2", 32'(iss_ins2), 'h5222);
    check("e_mask", 32'(iss_mask), 'hA);
    tick();
    outs = 4'b0000;
    #1 check("e_hist0", 32'(hist), 'h0);

    // Empty group is consumed without entering HOLD
    offer(4'b0000, 16'h7777, 16'h7777, 16'h7777, 16'h7777);
    #1 check("f_ready", 32'(grp_ready), 'h1);
    tick();
    grp_valid = 1'b0;
    #1;
    check("f_busy", 32'(busy), 'h0);
    check("f_hist", 32'(hist), 'h0);

    // Zero grants while not stalled trigger the sticky hang flag
    offer(4'b0001, 16'h6001, 16'h0000, 16'h0000, 16'h0000);
    tick();
    grp_valid = 1'b0;
    tick(); tick(); tick();
    check("g_hang3", 32'(hang), 'h0);
    tick();
    check("g_hang4", 32'(hang), STATS ? 'h1 : 'h0);
    check("g_hist", 32'(hist), 'h1);
    outs = 4'b0001;
    tick();
    outs = 4'b0000;
    #1;
    check("g_hang_sticky", 32'(hang), STATS ? 'h1 : 'h0);
    check("g_replay", 32'(replay_cnt), STATS ? 'h1 : 'h0);

    // Reset mid-group discards it and clears stats
    offer(4'b1111, 16'h8001, 16'h8002, 16'h8003, 16'h8004);
    tick();
    grp_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; outs = 4'b1111;
    #1;
    check("h_mask", 32'(iss_mask), 'h0);
    check("h_hist", 32'(hist), 'h0);
    check("h_busy", 32'(busy), 'h0);
    check("h_hang", 32'(hang), 'h0);
    check("h_replay", 32'(replay_cnt), 'h0);
    check("h_op1", 32'(op1), 'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/issue_group_buffer.md
# issue_group_buffer

Holds one fetched group of four instructions and feeds it to the load/store issue checker until every valid slot has issued. Drives the checker's per-slot opcode and history (still-pending) inputs, consumes its per-slot issue grants, retires granted slots, and requests the next group once the current one is fully drained. Sits between the fetch/decode group register and the load/store checker / ALU routing stage.

## Interface
Parameters:
- INS_W, 16, instruction word width; opcode is bits [INS_W-1 -: 4]
- HANG_LIMIT, 4, consecutive non-stalled zero-grant cycles before hang is flagged

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- grp_valid  in  1  new group offered
- grp_ready  out  1  buffer accepts group this cycle
- grp_vmask  in  4  per-slot valid bits of offered group (bit0 = ins1)
- grp_ins1..grp_ins4  in  INS_W  offered instruction words
- op1..op4  out  4  opcode of held slot to checker
- ins1_history..ins4_history  out  1  slot held and not yet issued
- ins1_out..ins4_out  in  1  issue grant from checker
- stall  in  1  downstream cannot accept issue this cycle
- iss_mask  out  4  slots issued this cycle
- iss_ins1..iss_ins4  out  INS_W  held instruction words
- busy  out  1  group held (state HOLD)
- hang  out  1  sticky: checker stopped granting pending slots
- replay_cnt  out  16  groups needing more than one issue cycle (see Configuration)

## Operation
- State machine: IDLE, HOLD. Registers: ins[4], pending[4], first (1 = no issue cycle yet for group), hang_cnt, hang.
- history = pending (registered); opN = ins[N][INS_W-1 -: 4] (registered).
- grant = pending & {ins4_out..ins1_out} & {4{~stall}}; grants on non-pending slots ignored. iss_mask = grant (combinational).
- pend_next = pending & ~grant.
- grp_ready = (state==IDLE) | (state==HOLD & pend_next==0).
- Accept = grp_valid & grp_ready: ins <= grp_ins, pending <= grp_vmask, first <= 1; state <= HOLD if grp_vmask != 0, else IDLE (empty group consumed, dropped).
- HOLD without accept: pending <= pend_next; if pend_next==0 -> IDLE. Any grant clears first.
- Group retired with first==0 at drain -> replay_cnt increments (saturates at 16'hFFFF).
- hang_cnt: in HOLD, !stall, grant==0 -> +1; else clears. Reaching HANG_LIMIT sets hang (sticky until rst). Buffer keeps presenting slots; hang is diagnostic only.
- stall: no slot retires, hang_cnt holds, history unchanged.

## Timing
- Reset: state IDLE, pending 0, all history 0, op 0, iss_mask 0 (pending 0), ins 0, hang 0, hang_cnt 0, replay_cnt 0, busy 0, grp_ready 1.
- Accepted group visible on op/history the cycle after accept.
- Grant in cycle t retires slot; history drops at t+1.
- Back-to-back: final grant and new accept in same cycle -> new group on history at t+1, zero bubble.
- Reset mid-group discards held group; no iss_mask after reset.
- grp_ready is combinational from ins*_out and stall; no combinational path from grp_* to any output.

## Configuration
- ISSUE_STATS_EN defined: replay_cnt counter and hang detection implemented as above.
- Undefined: replay_cnt tied 0, hang tied 0, hang_cnt removed; issue behaviour identical.

## Test plan
- Reset, then grp_vmask=4'b1111, all ALU ops, checker grants 4'b1111 -> history 1111 one cycle, iss_mask 1111, IDLE next cycle, replay_cnt 0.
- Group with slots 1 and 3 loads (op 4'b0010); grants 0011 then 1100 -> iss_mask 0011, 1100; history 1111 -> 1100 -> 0000; replay_cnt 1.
- stall=1 for 3 cycles with grants 1111 -> iss_mask 0000, history stays 1111, hang 0; release -> drains in one cycle.
- Final grant cycle with grp_valid=1 -> grp_ready=1, new group history next cycle, no idle cycle.
- grp_vmask=0000 offered -> accepted, busy stays 0, history stays 0000.
- Non-stalled zero grants for 4 cycles -> hang=1, persists after later grants; rst clears; without ISSUE_STATS_EN hang stays 0.
